// File: rtl/ceil_div_sched.sv
// ----------------------------------------------------------------------------
// ceil_div_sched
//
// Shared runtime ceiling divider. NumReq requesters compete for one bit-serial
// restoring divider through a round-robin arbiter; the winner's operands are
// latched on the handshake and ceil(dividend/divisor) is returned with the
// owning requester's index. One quotient bit is produced per cycle, so a
// normal operation takes Width CALC cycles followed by a RESP cycle.
//
// Ports:
//   clk_i         clock, rising edge
//   rst_ni        asynchronous active-low reset
//   req_valid_i   [NumReq]        per-requester operand valid
//   req_ready_o   [NumReq]        per-requester accept (one-hot or zero)
//   dividend_i    [NumReq*Width]  packed dividends, requester r at [r*Width +: Width]
//   divisor_i     [NumReq*Width]  packed divisors, same packing
//   rsp_valid_o   result valid (registered)
//   rsp_ready_i   result consumer ready
//   rsp_idx_o     [IdxW]          index of the requester owning the result
//   quotient_o    [Width]         ceil(dividend/divisor), all-ones on divide by zero
//   div_zero_o    divisor was zero
//   busy_o        high whenever the FSM is not idle
// ----------------------------------------------------------------------------
module ceil_div_sched #(
    parameter int NumReq = 4,
    parameter int Width  = 32,
    // Derived requester index width; at least one bit even for a single requester.
    parameter int IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NumReq-1:0]       req_valid_i,
    output logic [NumReq-1:0]       req_ready_o,
    input  logic [NumReq*Width-1:0] dividend_i,
    input  logic [NumReq*Width-1:0] divisor_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [IdxW-1:0]         rsp_idx_o,
    output logic [Width-1:0]        quotient_o,
    output logic                    div_zero_o,
    output logic                    busy_o
);

    localparam int CntW = $clog2(Width);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_e            state_q,     state_d;
    logic [IdxW-1:0]   rr_q,        rr_d;
    logic [Width-1:0]  dvd_q,       dvd_d;      // dividend, shifted out MSB first
    logic [Width-1:0]  dvs_q,       dvs_d;      // latched divisor
    // The partial remainder is always below the divisor between steps, so
    // Width bits hold it; the extra bit only exists inside a step.
    logic [Width-1:0]  rem_q,       rem_d;
    // The first Width-1 quotient bits; the last bit is produced in the
    // final CALC cycle and goes straight into the rounded result.
    logic [Width-2:0]  quo_q,       quo_d;
    logic [CntW-1:0]   cnt_q,       cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [IdxW-1:0]   rsp_idx_q,   rsp_idx_d;
    logic [Width-1:0]  quotient_q,  quotient_d;
    logic              div_zero_q,  div_zero_d;
    logic              busy_q,      busy_d;

    // ------------------------------------------------------------------
    // Operand unpacking
    // ------------------------------------------------------------------
    logic [Width-1:0] dividend_arr [NumReq];
    logic [Width-1:0] divisor_arr  [NumReq];

    generate
        for (genvar gi = 0; gi < NumReq; gi++) begin : g_unpack
            assign dividend_arr[gi] = dividend_i[gi*Width +: Width];
            assign divisor_arr[gi]  = divisor_i[gi*Width +: Width];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin arbiter: first valid requester at or above rr_q, wrapping.
    // ------------------------------------------------------------------
    logic              grant_any;
    logic [IdxW-1:0]   grant_idx;
    logic [IdxW-1:0]   cand_idx;
    logic [NumReq-1:0] grant_oh;

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand_idx  = '0;
        for (int i = 0; i < NumReq; i++) begin
            cand_idx = IdxW'((int'(rr_q) + i) % NumReq);
            if (!grant_any && req_valid_i[cand_idx]) begin
                grant_any = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    assign grant_oh = grant_any ? (NumReq'(1) << grant_idx) : '0;

    // Accept only in IDLE; the reset term keeps the accept low while the
    // block is held in reset even though the state already reads IDLE.
    assign req_ready_o = (state_q == ST_IDLE && rst_ni) ? grant_oh : '0;

    // ------------------------------------------------------------------
    // One restoring-division step
    // ------------------------------------------------------------------
    logic [Width:0]   rem_shift;
    logic [Width+1:0] rem_diff;
    logic             borrow;
    logic [Width:0]   rem_new;
    logic [Width-1:0] quo_new;
    logic             rem_nz;

    always_comb begin
        rem_shift = {rem_q, dvd_q[Width-1]};
        rem_diff  = {1'b0, rem_shift} - {2'b00, dvs_q};
        borrow    = rem_diff[Width+1];
        rem_new   = borrow ? rem_shift : rem_diff[Width:0];
        quo_new   = {quo_q, ~borrow};
        rem_nz    = |rem_new;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_idx_d   = rsp_idx_q;
        quotient_d  = quotient_q;
        div_zero_d  = div_zero_q;
        busy_d      = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    rr_d      = IdxW'((int'(grant_idx) + 1) % NumReq);
                    rsp_idx_d = grant_idx;
                    busy_d    = 1'b1;
                    if (divisor_arr[grant_idx] == '0) begin
                        // Divide by zero skips the datapath entirely.
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        quotient_d  = '1;
                        div_zero_d  = 1'b1;
                    end else begin
                        state_d    = ST_CALC;
                        dvd_d      = dividend_arr[grant_idx];
                        dvs_d      = divisor_arr[grant_idx];
                        rem_d      = '0;
                        quo_d      = '0;
                        cnt_d      = CntW'(Width - 1);
                        div_zero_d = 1'b0;
                    end
                end
            end

            ST_CALC: begin
                dvd_d = {dvd_q[Width-2:0], 1'b0};
                rem_d = rem_new[Width-1:0];
                quo_d = quo_new[Width-2:0];
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    // Round up on a nonzero remainder. A full quotient only
                    // arises for divisor 1, which leaves no remainder, so
                    // the increment never wraps.
                    quotient_d  = quo_new + {{(Width-1){1'b0}}, rem_nz};
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end
            end

            ST_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            rr_q        <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_idx_q   <= '0;
            quotient_q  <= '0;
            div_zero_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_idx_q   <= rsp_idx_d;
            quotient_q  <= quotient_d;
            div_zero_q  <= div_zero_d;
            busy_q      <= busy_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_idx_o   = rsp_idx_q;
    assign quotient_o  = quotient_q;
    assign div_zero_o  = div_zero_q;
    assign busy_o      = busy_q;

endmodule
